// File: rtl/fcp6_pkg.sv
// Shared constants and FSM encoding for the FCP6 master arbiter.
package fcp6_pkg;

  localparam int unsigned FCP6_BYTE_W          = 8;
  localparam int unsigned FCP6_TIMEOUT_DEFAULT = 255;

  typedef enum logic [2:0] {
    StIdle     = 3'd0,
    StLaunch   = 3'd1,
    StWaitBusy = 3'd2,
    StWaitDone = 3'd3,
    StFinish   = 3'd4
  } arb_state_e;

endpackage

// File: rtl/fcp6_rr_pick.sv
// Round-robin winner select: rotate requests by ptr, take the lowest set bit, rotate back.
module fcp6_rr_pick
  import fcp6_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic               valid_o,
  output logic [IDX_W-1:0]   idx_o
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [2*NUM_REQ-1:0] rot_wide;
  logic [NUM_REQ-1:0]   rot;
  logic [IDX_W-1:0]     enc;
  logic [IDX_W:0]       sum;

  always_comb begin
    req_dbl  = {req_i, req_i};
    rot_wide = req_dbl >> ptr_i;
    rot      = rot_wide[NUM_REQ-1:0];

    enc = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (rot[i]) enc = IDX_W'(i);
    end
    valid_o = |rot;

    // Undo the rotation modulo NUM_REQ, which need not be a power of two.
    sum = {1'b0, enc} + {1'b0, ptr_i};
    if (sum >= (IDX_W + 1)'(NUM_REQ)) sum = sum - (IDX_W + 1)'(NUM_REQ);
    idx_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fcp6_master_arbiter.sv
// Round-robin sequencer sharing one FCP6 master between NUM_REQ requesters.
// Define FCP6_ARB_TIMEOUT_EN to add a busy-handshake watchdog that reports err instead of done.
module fcp6_master_arbiter
  import fcp6_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2,
  parameter int unsigned TIMEOUT = FCP6_TIMEOUT_DEFAULT
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_REQ-1:0]             req,
  input  logic [NUM_REQ*FCP6_BYTE_W-1:0] req_header,
  input  logic [NUM_REQ*FCP6_BYTE_W-1:0] req_data,
  output logic [NUM_REQ-1:0]             gnt,
  output logic [NUM_REQ-1:0]             done,
  output logic [NUM_REQ-1:0]             err,
  output logic                           m_start,
  output logic [FCP6_BYTE_W-1:0]         m_header,
  output logic [FCP6_BYTE_W-1:0]         m_data,
  input  logic                           m_busy,
  output logic                           arb_busy
);

  arb_state_e               state_q, state_d;
  logic [NUM_REQ-1:0]       gnt_q, gnt_d;
  logic [NUM_REQ-1:0]       done_q, done_d;
  logic                     m_start_q, m_start_d;
  logic [FCP6_BYTE_W-1:0]   m_header_q, m_header_d;
  logic [FCP6_BYTE_W-1:0]   m_data_q, m_data_d;
  logic [IDX_W-1:0]         ptr_q, ptr_d;
  logic [IDX_W-1:0]         win_q, win_d;

  logic                     pick_valid;
  logic [IDX_W-1:0]         pick_idx;
  logic [IDX_W-1:0]         ptr_next;
  logic [FCP6_BYTE_W-1:0]   pick_hdr, pick_dat;
  logic [NUM_REQ-1:0]       pick_onehot;

  fcp6_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  always_comb begin
    pick_hdr    = '0;
    pick_dat    = '0;
    pick_onehot = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick_idx == IDX_W'(i)) begin
        pick_hdr       = req_header[i*FCP6_BYTE_W +: FCP6_BYTE_W];
        pick_dat       = req_data[i*FCP6_BYTE_W +: FCP6_BYTE_W];
        pick_onehot[i] = 1'b1;
      end
    end
    ptr_next = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
  end

`ifdef FCP6_ARB_TIMEOUT_EN
  localparam int unsigned WdogW = (TIMEOUT > 255) ? 16 : 8;
  logic [WdogW-1:0]   wdog_q, wdog_d;
  logic [NUM_REQ-1:0] err_q, err_d;
  logic               wdog_hit;

  assign wdog_hit = (wdog_q == WdogW'(TIMEOUT - 1));
`endif

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    done_d     = '0;
    m_start_d  = 1'b0;
    m_header_d = m_header_q;
    m_data_d   = m_data_q;
    ptr_d      = ptr_q;
    win_d      = win_q;
`ifdef FCP6_ARB_TIMEOUT_EN
    err_d  = '0;
    wdog_d = wdog_q;
`endif

    unique case (state_q)
      StIdle: begin
        // Busy while idle means someone else owns the master; hold off.
        if (pick_valid && !m_busy) begin
          gnt_d      = pick_onehot;
          win_d      = pick_idx;
          m_header_d = pick_hdr;
          m_data_d   = pick_dat;
          state_d    = StLaunch;
        end
      end
      StLaunch: begin
        m_start_d = 1'b1;
        state_d   = StWaitBusy;
`ifdef FCP6_ARB_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      StWaitBusy: begin
        if (m_busy) begin
          state_d = StWaitDone;
`ifdef FCP6_ARB_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_hit) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
`endif
        end
      end
      StWaitDone: begin
        if (!m_busy) begin
          state_d = StFinish;
`ifdef FCP6_ARB_TIMEOUT_EN
        end else if (wdog_hit) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          ptr_d   = ptr_next;
          state_d = StIdle;
        end else begin
          wdog_d = wdog_q + WdogW'(1);
`endif
        end
      end
      StFinish: begin
        done_d  = gnt_q;
        gnt_d   = '0;
        ptr_d   = ptr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= StIdle;
      gnt_q      <= '0;
      done_q     <= '0;
      m_start_q  <= 1'b0;
      m_header_q <= '0;
      m_data_q   <= '0;
      ptr_q      <= '0;
      win_q      <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      done_q     <= done_d;
      m_start_q  <= m_start_d;
      m_header_q <= m_header_d;
      m_data_q   <= m_data_d;
      ptr_q      <= ptr_d;
      win_q      <= win_d;
    end
  end

`ifdef FCP6_ARB_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      wdog_q <= '0;
      err_q  <= '0;
    end else begin
      wdog_q <= wdog_d;
      err_q  <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = '0;
`endif

  assign gnt      = gnt_q;
  assign done     = done_q;
  assign m_start  = m_start_q;
  assign m_header = m_header_q;
  assign m_data   = m_data_q;
  assign arb_busy = (state_q != StIdle);

endmodule

// File: tb/tb_fcp6_master_arbiter.sv
// Directed bench for fcp6_master_arbiter; the master's busy handshake is driven by hand.
module tb_fcp6_master_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_header;
  logic [31:0] req_data;
  logic [3:0]  gnt;
  logic [3:0]  done;
  logic [3:0]  err;
  logic        m_start;
  logic [7:0]  m_header;
  logic [7:0]  m_data;
  logic        m_busy;
  logic        arb_busy;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fcp6_master_arbiter #(
    .NUM_REQ (4),
    .IDX_W   (2),
    .TIMEOUT (10)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_header (req_header),
    .req_data   (req_data),
    .gnt        (gnt),
    .done       (done),
    .err        (err),
    .m_start    (m_start),
    .m_header   (m_header),
    .m_data     (m_data),
    .m_busy     (m_busy),
    .arb_busy   (arb_busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic set_hd(input int i, input logic [7:0] h, input logic [7:0] d);
    req_header[i*8 +: 8] = h;
    req_data[i*8 +: 8]   = d;
  endtask

  // One complete frame: expects the given grant, releases 'rel' bits of req on done.
  task automatic frame(input string tag, input logic [3:0] exp_gnt, input logic [7:0] eh,
                       input logic [7:0] ed, input logic [3:0] rel, input bit late);
    for (int i = 0; i < 20 && gnt == 4'b0; i++) @(negedge clk);
    check({tag, ":gnt"}, 32'(gnt), 32'(exp_gnt));
    check({tag, ":hdr"}, 32'(m_header), 32'(eh));
    check({tag, ":dat"}, 32'(m_data), 32'(ed));
    if (late) begin
      req[2]            = 1'b0;
      req_header[23:16] = 8'hFF;
      req_data[23:16]   = 8'hFF;
    end
    for (int i = 0; i < 5 && !m_start; i++) @(negedge clk);
    check({tag, ":start"}, 32'(m_start), 32'd1);
    @(negedge clk);
    check({tag, ":start_pulse"}, 32'(m_start), 32'd0);
    @(negedge clk);
    m_busy = 1'b1;
    repeat (6) @(negedge clk);
    check({tag, ":gnt_hold"}, 32'(gnt), 32'(exp_gnt));
    m_busy = 1'b0;
    @(negedge clk);
    check({tag, ":done_early"}, 32'(done), 32'd0);
    @(negedge clk);
    check({tag, ":done"}, 32'(done), 32'(exp_gnt));
    check({tag, ":gnt_clr"}, 32'(gnt), 32'd0);
    check({tag, ":hdr_end"}, 32'(m_header), 32'(eh));
    check({tag, ":err"}, 32'(err), 32'd0);
    req = req & ~rel;
    @(negedge clk);
    check({tag, ":done_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    rst        = 1'b0;
    req        = '0;
    req_header = '0;
    req_data   = '0;
    m_busy     = 1'b0;
    repeat (2) @(negedge clk);
    check("rst:gnt", 32'(gnt), 32'd0);
    check("rst:done", 32'(done), 32'd0);
    check("rst:err", 32'(err), 32'd0);
    check("rst:start", 32'(m_start), 32'd0);
    check("rst:hdr", 32'(m_header), 32'd0);
    check("rst:dat", 32'(m_data), 32'd0);
    check("rst:arb_busy", 32'(arb_busy), 32'd0);

    set_hd(0, 8'hA5, 8'h3C);
    set_hd(1, 8'h11, 8'h22);
    set_hd(2, 8'h33, 8'h44);
    set_hd(3, 8'h55, 8'h66);
    rst = 1'b1;
    req = 4'b0001;
    frame("single", 4'b0001, 8'hA5, 8'h3C, 4'b0001, 1'b0);

    // Foreign busy blocks the pick; afterwards ptr=1 must favour requester 1 over 0.
    m_busy = 1'b1;
    req    = 4'b0011;
    repeat (3) @(negedge clk);
    check("foreign:gnt", 32'(gnt), 32'd0);
    check("foreign:arb_busy", 32'(arb_busy), 32'd0);
    m_busy = 1'b0;
    frame("ptr1", 4'b0010, 8'h11, 8'h22, 4'b0010, 1'b0);
    frame("ptr2", 4'b0001, 8'hA5, 8'h3C, 4'b0001, 1'b0);

    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    req = 4'b1111;
    frame("all0", 4'b0001, 8'hA5, 8'h3C, 4'b0000, 1'b0);
    frame("all1", 4'b0010, 8'h11, 8'h22, 4'b0000, 1'b0);
    frame("all2", 4'b0100, 8'h33, 8'h44, 4'b0000, 1'b0);
    frame("all3", 4'b1000, 8'h55, 8'h66, 4'b0000, 1'b0);
    frame("all4", 4'b0001, 8'hA5, 8'h3C, 4'b1111, 1'b0);

    req = 4'b0100;
    frame("wrap_pre", 4'b0100, 8'h33, 8'h44, 4'b0100, 1'b0);
    req = 4'b1001;
    frame("wrap3", 4'b1000, 8'h55, 8'h66, 4'b1000, 1'b0);
    frame("wrap0", 4'b0001, 8'hA5, 8'h3C, 4'b0001, 1'b0);

    set_hd(2, 8'h5A, 8'h77);
    req = 4'b0100;
    frame("late", 4'b0100, 8'h5A, 8'h77, 4'b0000, 1'b1);

    // Reset in WAIT_DONE; ptr was 3, so 1 wins first.
    req = 4'b0010;
    for (int i = 0; i < 20 && gnt == 4'b0; i++) @(negedge clk);
    check("midrst:gnt", 32'(gnt), 32'b0010);
    for (int i = 0; i < 5 && !m_start; i++) @(negedge clk);
    @(negedge clk);
    m_busy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst:gnt0", 32'(gnt), 32'd0);
    check("midrst:start0", 32'(m_start), 32'd0);
    check("midrst:hdr0", 32'(m_header), 32'd0);
    check("midrst:dat0", 32'(m_data), 32'd0);
    check("midrst:arb_busy0", 32'(arb_busy), 32'd0);
    m_busy = 1'b0;
    req    = 4'b0000;
    rst    = 1'b1;
    for (int i = 0; i < 4; i++) begin
      check("midrst:no_done", 32'(done), 32'd0);
      @(negedge clk);
    end
    // ptr must be back at 0: requester 0 ahead of 3.
    req = 4'b1001;
    frame("postrst0", 4'b0001, 8'hA5, 8'h3C, 4'b0001, 1'b0);
    frame("postrst3", 4'b1000, 8'h55, 8'h66, 4'b1000, 1'b0);

`ifdef FCP6_ARB_TIMEOUT_EN
    req = 4'b0110;
    for (int i = 0; i < 20 && gnt == 4'b0; i++) @(negedge clk);
    check("wd:gnt", 32'(gnt), 32'b0010);
    for (int i = 0; i < 5 && !m_start; i++) @(negedge clk);
    check("wd:start", 32'(m_start), 32'd1);
    repeat (9) @(negedge clk);
    check("wd:err_early", 32'(err), 32'd0);
    @(negedge clk);
    check("wd:err", 32'(err), 32'b0010);
    check("wd:done", 32'(done), 32'd0);
    check("wd:gnt_clr", 32'(gnt), 32'd0);
    req[1] = 1'b0;
    @(negedge clk);
    check("wd:next_gnt", 32'(gnt), 32'b0100);
    frame("wd_next", 4'b0100, 8'h33, 8'h44, 4'b0100, 1'b0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
